// File: rtl/fifo_stream_downsizer.sv
// Drains a first-word-fall-through FIFO and serializes each word into InWidth/OutWidth beats on a valid/ready stream.
// Define FIFO_STREAM_DOWNSIZER_MSB_FIRST_EN to emit the most significant slice first (default: least significant first).
//
// state | meaning
// IDLE  | no word held; pops as soon as the FIFO is non-empty
// SHIFT | word held in sh_reg; beats presented on the output stream
module fifo_stream_downsizer #(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifoEmpty,
  input  logic [InWidth-1:0]  fifoReadData,
  output logic                fifoReadEn,
  output logic                outValid,
  output logic [OutWidth-1:0] outData,
  output logic                outLast,
  input  logic                outReady,
  output logic                busy
);

  localparam int Ratio = InWidth / OutWidth;
  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  generate
    if ((InWidth % OutWidth) != 0 || (InWidth / OutWidth) < 2) begin : g_bad_width
      $error("fifo_stream_downsizer: InWidth must be a multiple of OutWidth with ratio >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  state_t              state_next;
  logic [InWidth-1:0]  sh_reg;
  logic [InWidth-1:0]  sh_shifted;
  logic [CntW-1:0]     beat_cnt;
  logic                valid_q;
  logic                xfer;
  logic                at_last;
  logic                load;
  logic                advance;
  logic                drain;

  assign xfer    = valid_q && outReady;
  assign at_last = (beat_cnt == LastCnt);

`ifdef FIFO_STREAM_DOWNSIZER_MSB_FIRST_EN
  assign sh_shifted = {sh_reg[InWidth-OutWidth-1:0], {OutWidth{1'b0}}};
  assign outData    = sh_reg[InWidth-1 -: OutWidth];
`else
  assign sh_shifted = {{OutWidth{1'b0}}, sh_reg[InWidth-1:OutWidth]};
  assign outData    = sh_reg[OutWidth-1:0];
`endif

  assign outValid = valid_q;
  assign outLast  = at_last && valid_q;
  assign busy     = (state == SHIFT);

  always_comb begin
    state_next = state;
    fifoReadEn = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoReadEn = 1'b1;
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (!at_last) begin
            advance = 1'b1;
          end else if (!fifoEmpty) begin
            // last beat leaves while the next word is captured: no bubble
            fifoReadEn = 1'b1;
            load       = 1'b1;
          end else begin
            drain      = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      fifoReadEn = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh_reg   <= '0;
      beat_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        sh_reg   <= fifoReadData;
        beat_cnt <= '0;
        valid_q  <= 1'b1;
      end else if (advance) begin
        sh_reg   <= sh_shifted;
        beat_cnt <= beat_cnt + CntW'(1);
      end else if (drain) begin
        // the final shift empties sh_reg, so outData idles at zero
        sh_reg   <= sh_shifted;
        beat_cnt <= '0;
        valid_q  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_stream_downsizer.md
# fifo_stream_downsizer

Read-side drain stage placed directly downstream of a first-word-fall-through FIFO. It pops one InWidth-bit word whenever the FIFO is non-empty and the stage is free. Each word is serialized into Ratio = InWidth/OutWidth narrower beats on a valid/ready output stream. Sustained throughput is one beat per cycle with no bubbles between words.

## Interface
- InWidth, 32, FIFO word width; must equal the upstream FIFO DataWidth
- OutWidth, 8, output beat width; InWidth % OutWidth == 0 and InWidth/OutWidth >= 2, else $error at elaboration
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- fifoEmpty  input  1  upstream FIFO empty flag
- fifoReadData  input  InWidth  upstream FIFO head word; valid whenever fifoEmpty is 0
- fifoReadEn  output  1  pop strobe to FIFO; combinational
- outValid  output  1  beat valid; registered
- outData  output  OutWidth  beat payload; registered
- outLast  output  1  high on the final beat of a word; registered
- outReady  input  1  downstream accepts beat when high with outValid
- busy  output  1  high while a word is held (state SHIFT)

## Operation
- Internal state:
  - FSM {IDLE, SHIFT}.
  - Shift register shReg[InWidth-1:0].
  - Beat counter beatCnt of width $clog2(Ratio).
- Handshake: a beat transfers in any cycle with outValid && outReady.
- IDLE:
  - fifoReadEn = !fifoEmpty.
  - On pop: shReg <= fifoReadData, beatCnt <= 0, outValid <= 1, go SHIFT.
- SHIFT, no transfer:
  - All registers hold; outData and outLast are stable under backpressure.
- SHIFT, transfer with beatCnt < Ratio-1:
  - beatCnt increments and shReg shifts by OutWidth.
  - fifoReadEn = 0.
- SHIFT, transfer with beatCnt == Ratio-1:
  - fifoReadEn = !fifoEmpty.
  - If popping: reload shReg, beatCnt <= 0, stay in SHIFT (zero-bubble chaining).
  - Otherwise: outValid <= 0, go IDLE.
- outData is the current slice of shReg. outLast = (beatCnt == Ratio-1) && outValid.
- fifoReadEn is never asserted while fifoEmpty=1 or rst=1. At most one pop per cycle.
- The stage holds at most one word. fifoReadEn has no combinational path from outReady except in the last-beat case.
- Reset outputs: outValid=0, outData=0, outLast=0, busy=0, fifoReadEn=0. State IDLE, beatCnt=0, shReg=0.
- Reset mid-word: the partially sent word is discarded and no further beats from it are emitted. The FIFO is not re-popped for it.

## Timing
- Latency: fifoEmpty low in IDLE at cycle N → pop in cycle N → first beat outValid=1 in cycle N+1.
- With outReady held high, a word occupies exactly Ratio consecutive beat cycles.
- Back-to-back words: the last beat of word k and the first beat of word k+1 are in consecutive cycles.
- outValid, once high, stays high until a transfer occurs (no retraction).
- The FIFO sees its pop in the same cycle the word is captured. FIFO pointer update and shReg load occur on the same edge.
- After reset deassertion, the earliest pop is the first cycle with rst=0.

## Configuration
- Macro: FIFO_STREAM_DOWNSIZER_MSB_FIRST_EN.
- Undefined (default), LSB first:
  - Beat 0 = word[OutWidth-1:0].
  - shReg shifts right by OutWidth per transfer.
- Defined, MSB first:
  - Beat 0 = word[InWidth-1:InWidth-OutWidth].
  - shReg shifts left by OutWidth per transfer.
- Everything else, including timing and flags, is identical in both builds.

## Test plan
- Reset: assert rst 3 cycles with fifoEmpty=0 → fifoReadEn=0, outValid=0, outData=0, outLast=0, busy=0 throughout.
- Single word 0xA1B2C3D4, outReady=1, default build → fifoReadEn pulses once. Beats are 0xD4, 0xC3, 0xB2, 0xA1 in 4 consecutive cycles starting 1 cycle after the pop. outLast is high only on 0xA1, then the stage returns to IDLE.
- Backpressure: same word, outReady low for 3 cycles during beat 1 → outData holds 0xC3 with outValid high. The sequence then resumes unchanged, and no extra pop occurs.
- Back-to-back words 0x11223344 then 0x55667788, FIFO pre-filled, outReady=1 → 8 consecutive beats 44,33,22,11,88,77,66,55 with no gap. The second pop coincides with beat 11; outLast is high on 11 and 55.
- Reset mid-word: rst asserted after beat 2 of 0xA1B2C3D4 → outValid=0 the next cycle and the remaining beats are never emitted. The next FIFO word starts fresh at beat 0.
- MSB build (FIFO_STREAM_DOWNSIZER_MSB_FIRST_EN defined), word 0xA1B2C3D4 → beats 0xA1, 0xB2, 0xC3, 0xD4, with outLast on 0xD4.
